seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
//  - Holds a 16-bit display value and steps through its four nibbles.
//  - Presents one nibble at a time to the hex-to-segment decoder downstream.
//  - Drives the matching active-low anode plus the decimal point.
//  - Provides tear-free value updates, leading-zero blanking and an anti-ghost guard interval.
// PARAMETERS
//  CLK_DIV  50000  clk cycles per digit slot (1 kHz digit rate at 50 MHz); CLK_DIV >= GUARD+2
//  GUARD    16     cycles at the start of each slot with all anodes off (anti-ghosting)
// PORTS
//  clk          in   1   single system clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  load         in   1   1-cycle strobe: request display of value/dp_in
//  value        in   16  digit i = value[4i+3:4i]; digit 0 is rightmost
//  dp_in        in   4   dp_in[i]=1 lights the decimal point of digit i
//  lz_blank     in   1   1 = suppress leading zeros (live input, not latched)
//  digit_nibble out  4   nibble for the decoder, registered
//  anode_n      out  4   anode_n[i]=0 enables digit i; at most one bit low
//  dp_n         out  1   active-low decimal point for the enabled digit
//  frame_tick   out  1   1-cycle pulse on the last cycle of the digit-3 slot
// BEHAVIOUR
//  Reset:
//   - shadow value=0, shadow dp=0, pending=0, cnt=0, idx=0.
//   - Outputs: digit_nibble=0, anode_n=4'b1111, dp_n=1, frame_tick=0.
//   - Reset mid-scan aborts the slot and discards any pending load.
//  Counters:
//   - cnt counts 0..CLK_DIV-1 and wraps to 0.
//   - On wrap, idx advances 0->1->2->3->0.
//   - frame_tick is asserted when cnt==CLK_DIV-1 && idx==3 (frame boundary).
//  Load (tear-free):
//   - load sets pending and captures value/dp_in into a staging register.
//   - A later load before the boundary overwrites staging; the newest value wins.
//   - At the frame boundary, staging->shadow and pending clears.
//   - load in the same cycle as the boundary: the new data goes straight to shadow and pending stays 0.
//   - The displayed value never changes mid-frame.
//  Outputs:
//   - All outputs are registered; each reflects cnt/idx/shadow of the previous cycle (latency 1).
//   - digit_nibble = shadow nibble idx, at all times, including during the guard interval.
//   - anode_n:
//     - all 1 while cnt < GUARD;
//     - otherwise ~(1<<idx), unless digit idx is blanked.
//   - dp_n = ~shadow_dp[idx] when the anode is on, else 1.
//  Leading-zero blanking:
//   - If lz_blank=1, digit i (i=3..1) is blanked when shadow nibbles 3..i are all zero.
//   - Digit 0 is never blanked, so a value of 0 shows a single "0".
//   - A blanked digit keeps its anode off for the whole slot; dp_n stays 1 for it.
//   - Slot timing is unchanged (constant brightness).
//  Guard:
//   - GUARD=0 means no guard interval.
//   - No anode is ever low in two consecutive slots without an all-off cycle between them, when GUARD>0.
// STRUCTURE
//  Package seg_pkg:
//   - N_DIGITS=4.
//   - ANODE_OFF=4'b1111.
//   - Function anode_onehot_n(idx).
//  Sub-module tick_gen (CLK_DIV param, clk/rst in):
//   - Outputs cnt and a wrap pulse.
//   - Also reused by other timed blocks.
//  Top:
//   - idx counter, staging/shadow registers with pending flag.
//   - Blank-mask logic, output registers.
//   - digit_nibble feeds the existing hex-to-segment decoder directly.
// TESTING  (CLK_DIV=8, GUARD=2)
//  1. Reset, then idle 40 cycles:
//     - anode_n=1111 for the guard cycles of each slot;
//     - slot 0 shows 1110 with nibble 0;
//     - digits 1-3 are also shown (lz_blank=0);
//     - frame_tick every 32 cycles.
//  2. Scan sequence:
//     - load value=16'h12AF, dp_in=4'b0100.
//     - After the next boundary, slots show F,A,2,1 on anodes 1110,1101,1011,0111.
//     - dp_n=0 only in the digit-2 slot.
//  3. Tear-free update:
//     - load 16'h1111 mid-frame, then 16'h2222 before the boundary.
//     - The current frame stays old; the next frame shows 2 on all digits; 1111 is never displayed.
//  4. Leading-zero blanking:
//     - lz_blank=1 with 16'h0040: anode_n stays 1111 in slots 3 and 2; digit 1 shows 4; digit 0 shows 0.
//     - With 16'h0000, only digit 0 lights.
//  5. Boundary and reset corner cases:
//     - load coincident with frame_tick: the new value is shown from the very next slot.
//     - rst asserted mid-slot with a pending load: the next cycle gives anode_n=1111, and after the pending load is discarded the display shows 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan logic.
package seg_pkg;

   localparam int N_DIGITS = 4;
   localparam logic [N_DIGITS-1:0] ANODE_OFF = 4'b1111;

   // Active-low one-hot anode pattern for digit idx.
   function automatic logic [N_DIGITS-1:0] anode_onehot_n(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running slot counter: counts 0..CLK_DIV-1 and flags the last cycle.
module tick_gen #(
   parameter int CLK_DIV = 50000,
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   logic [CW-1:0] cnt_reg;

   assign wrap = (cnt_reg == CW'(CLK_DIV - 1));
   assign cnt  = cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (wrap) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// 4-digit common-anode display scanner with tear-free loads, leading-zero
// blanking and an all-off guard interval at the start of every digit slot.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int GUARD   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [15:0]   value,
   input  logic [3:0]    dp_in,
   input  logic          lz_blank,
   output logic [3:0]    digit_nibble,
   output logic [3:0]    anode_n,
   output logic          dp_n,
   output logic          frame_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0]         cnt;
   logic                  wrap;
   logic [1:0]            idx_reg;
   logic                  boundary;
   logic                  guard_active;

   logic [15:0]           stage_val_reg;
   logic [3:0]            stage_dp_reg;
   logic                  pending_reg;
   logic [15:0]           shadow_val_reg;
   logic [3:0]            shadow_dp_reg;

   logic [N_DIGITS-1:0]   blank_mask;
   logic                  anode_on;

   logic [3:0]            nibble_reg;
   logic [3:0]            anode_n_reg;
   logic                  dp_n_reg;
   logic                  frame_tick_reg;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .wrap (wrap)
   );

   assign boundary = wrap && (idx_reg == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg <= '0;
      end else if (wrap) begin
         idx_reg <= idx_reg + 1'b1;
      end
   end

   // Shadow only changes at the frame boundary, so a frame is never torn.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_val_reg  <= '0;
         stage_dp_reg   <= '0;
         pending_reg    <= 1'b0;
         shadow_val_reg <= '0;
         shadow_dp_reg  <= '0;
      end else if (boundary) begin
         pending_reg <= 1'b0;
         if (load) begin
            shadow_val_reg <= value;
            shadow_dp_reg  <= dp_in;
         end else if (pending_reg) begin
            shadow_val_reg <= stage_val_reg;
            shadow_dp_reg  <= stage_dp_reg;
         end
      end else if (load) begin
         stage_val_reg <= value;
         stage_dp_reg  <= dp_in;
         pending_reg   <= 1'b1;
      end
   end

   // Digit gi is blanked when it and every digit to its left are zero.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            assign blank_mask[gi] = 1'b0;
         end else begin : g_upper
            assign blank_mask[gi] = lz_blank && (shadow_val_reg[4*N_DIGITS-1:4*gi] == '0);
         end
      end
   endgenerate

   generate
      if (GUARD > 0) begin : g_guard
         assign guard_active = (cnt < CW'(GUARD));
      end else begin : g_noguard
         assign guard_active = 1'b0;
      end
   endgenerate

   assign anode_on = !guard_active && !blank_mask[idx_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         nibble_reg     <= '0;
         anode_n_reg    <= ANODE_OFF;
         dp_n_reg       <= 1'b1;
         frame_tick_reg <= 1'b0;
      end else begin
         nibble_reg     <= shadow_val_reg[4*idx_reg +: 4];
         anode_n_reg    <= anode_on ? anode_onehot_n(idx_reg) : ANODE_OFF;
         dp_n_reg       <= anode_on ? ~shadow_dp_reg[idx_reg] : 1'b1;
         frame_tick_reg <= boundary;
      end
   end

   assign digit_nibble = nibble_reg;
   assign anode_n      = anode_n_reg;
   assign dp_n         = dp_n_reg;
   assign frame_tick   = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Random and directed stimulus for seg_scan_mux, checked every cycle against a
// cycle-count based model of the display.
module tb_seg_scan_mux;

   localparam int CLK_DIV = 8;
   localparam int GUARD   = 2;
   localparam int FRAME   = 4 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        lz_blank = 1'b0;
   logic [3:0]  digit_nibble;
   logic [3:0]  anode_n;
   logic        dp_n;
   logic        frame_tick;

   int checks = 0;
   int failures = 0;

   // Model state: t is cycles since reset release.
   int          t = 0;
   logic [15:0] m_shadow = '0;
   logic [15:0] m_stage = '0;
   logic [3:0]  m_sdp = '0;
   logic [3:0]  m_stdp = '0;
   bit          m_pend = 0;
   logic [3:0]  e_nib, e_an;
   logic        e_dp, e_ft;
   logic [3:0]  prev_an = 4'hF;

   seg_scan_mux #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .value        (value),
      .dp_in        (dp_in),
      .lz_blank     (lz_blank),
      .digit_nibble (digit_nibble),
      .anode_n      (anode_n),
      .dp_n         (dp_n),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s t=%0d got=%h expected=%h", tag, t, obs, exp_v);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [15:0] v,
                       input logic [3:0] d, input logic lz);
      int  c, i;
      bit  lit, edge_b;
      rst = r; load = l; value = v; dp_in = d; lz_blank = lz;
      if (r) begin
         e_nib = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_ft = 1'b0;
         t = 0; m_shadow = '0; m_sdp = '0; m_pend = 0;
      end else begin
         c = t % CLK_DIV;
         i = (t / CLK_DIV) % 4;
         lit    = (c >= GUARD) && !(lz && i > 0 && (m_shadow >> (4 * i)) == 16'h0);
         edge_b = (c == CLK_DIV - 1) && (i == 3);
         e_nib  = 4'((m_shadow >> (4 * i)) & 16'hF);
         e_an   = lit ? ~(4'b0001 << i) : 4'hF;
         e_dp   = lit ? ~m_sdp[i] : 1'b1;
         e_ft   = edge_b;
         if (edge_b && l) begin
            m_shadow = v; m_sdp = d; m_pend = 0;
         end else if (edge_b) begin
            if (m_pend) begin m_shadow = m_stage; m_sdp = m_stdp; end
            m_pend = 0;
         end else if (l) begin
            m_stage = v; m_stdp = d; m_pend = 1;
         end
         t++;
      end
      @(negedge clk);
      chk("nibble", 16'(digit_nibble), 16'(e_nib));
      chk("anode_n", 16'(anode_n), 16'(e_an));
      chk("dp_n", 16'(dp_n), 16'(e_dp));
      chk("frame_tick", 16'(frame_tick), 16'(e_ft));
      chk("one_low", 16'($countones(~anode_n) <= 1), 16'd1);
      if (prev_an != 4'hF && anode_n != 4'hF)
         chk("ghost", 16'(anode_n), 16'(prev_an));
      prev_an = anode_n;
   endtask

   task automatic idle(input int n, input logic lz);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 4'h0, lz);
   endtask

   task automatic idle_until(input int phase, input logic lz);
      while ((t % FRAME) != phase) idle(1, lz);
   endtask

   initial begin
      logic        r, l, lz;
      logic [15:0] v;
      @(negedge clk);
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      idle(40, 1'b0);
      // scan sequence
      step(1'b0, 1'b1, 16'h12AF, 4'b0100, 1'b0);
      idle(70, 1'b0);
      // tear-free update
      idle_until(10, 1'b0);
      step(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
      idle(5, 1'b0);
      step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
      idle(64, 1'b0);
      // leading-zero blanking
      step(1'b0, 1'b1, 16'h0040, 4'h0, 1'b1);
      idle(70, 1'b1);
      step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
      idle(70, 1'b1);
      // load on the frame boundary cycle
      idle_until(FRAME - 1, 1'b1);
      step(1'b0, 1'b1, 16'h8765, 4'hF, 1'b1);
      idle(40, 1'b0);
      // reset with a pending load
      idle_until(5, 1'b0);
      step(1'b0, 1'b1, 16'h0ABC, 4'h3, 1'b0);
      idle(3, 1'b0);
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      idle(40, 1'b0);
      // randomized traffic
      lz = 1'b0;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 49) == 0) lz = ~lz;
         r = ($urandom_range(0, 199) == 0);
         l = ($urandom_range(0, 11) == 0);
         v = 16'($urandom) >> (4 * $urandom_range(0, 3));
         step(r, l, v, 4'($urandom), lz);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
